// File: rtl/alu_frame_sequencer.sv
// Collects operand 1, operand 2 and op code beats for the ALU, then captures
// and streams out the ALU result with an illegal-op status flag.
module alu_frame_sequencer #(
    parameter int NB_IN   = 8,
    parameter int NB_OUT  = 8,
    parameter int NB_CODE = 6,
    parameter int NB_CNT  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic [NB_IN-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [NB_IN-1:0]   alu_dato1,
    output logic [NB_IN-1:0]   alu_dato2,
    output logic [NB_CODE-1:0] alu_op_code,
    input  logic [NB_OUT-1:0]  alu_salida,
    output logic [NB_OUT-1:0]  res_data,
    output logic               res_err,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [NB_CNT-1:0]  frame_cnt
);

    typedef enum logic [2:0] {
        S_D1   = 3'd0,
        S_D2   = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SEND = 3'd4
    } state_t;

    state_t state;
    logic   accept;
    logic   illegal_op;

    assign accept = in_valid & in_ready;

    always_comb begin
        illegal_op = 1'b1;
        case (alu_op_code)
            NB_CODE'(6'b100000), NB_CODE'(6'b100010), NB_CODE'(6'b100100),
            NB_CODE'(6'b100101), NB_CODE'(6'b100110), NB_CODE'(6'b000011),
            NB_CODE'(6'b000010), NB_CODE'(6'b100111): illegal_op = 1'b0;
            default:                                  illegal_op = 1'b1;
        endcase
    end

    // in_ready is registered: it rises one edge after reset release and
    // drops on the same edge that moves the FSM into S_EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_D1;
            in_ready    <= 1'b0;
            alu_dato1   <= '0;
            alu_dato2   <= '0;
            alu_op_code <= '0;
            res_data    <= '0;
            res_err     <= 1'b0;
            res_valid   <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            case (state)
                S_D1, S_D2, S_OP: begin
                    in_ready <= 1'b1;
                    if (clear) begin
                        state <= S_D1;
                    end else if (accept) begin
                        case (state)
                            S_D1: begin
                                alu_dato1 <= in_data;
                                state     <= S_D2;
                            end
                            S_D2: begin
                                alu_dato2 <= in_data;
                                state     <= S_OP;
                            end
                            default: begin
                                alu_op_code <= in_data[NB_CODE-1:0];
                                in_ready    <= 1'b0;
                                state       <= S_EXEC;
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    res_data  <= illegal_op ? '0 : alu_salida;
                    res_err   <= illegal_op;
                    res_valid <= 1'b1;
                    state     <= S_SEND;
                end
                S_SEND: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        frame_cnt <= frame_cnt + NB_CNT'(1);
                        in_ready  <= 1'b1;
                        state     <= S_D1;
                    end
                end
                default: begin
                    state    <= S_D1;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_frame_sequencer.sv
// Directed bench for alu_frame_sequencer with a behavioural ALU on alu_salida.
module tb_alu_frame_sequencer;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] alu_dato1;
    logic [7:0] alu_dato2;
    logic [5:0] alu_op_code;
    logic [7:0] alu_salida;
    logic [7:0] res_data;
    logic       res_err;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] frame_cnt;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_cnt  = '0;
    logic [7:0] bb [6];
    logic [7:0] bexp [2];

    alu_frame_sequencer #(
        .NB_IN  (8),
        .NB_OUT (8),
        .NB_CODE(6),
        .NB_CNT (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_dato1  (alu_dato1),
        .alu_dato2  (alu_dato2),
        .alu_op_code(alu_op_code),
        .alu_salida (alu_salida),
        .res_data   (res_data),
        .res_err    (res_err),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Illegal codes return a nonzero pattern so forced-zero results are visible.
    always_comb begin
        case (alu_op_code)
            6'b100000: alu_salida = alu_dato1 + alu_dato2;
            6'b100010: alu_salida = alu_dato1 - alu_dato2;
            6'b100100: alu_salida = alu_dato1 & alu_dato2;
            6'b100101: alu_salida = alu_dato1 | alu_dato2;
            6'b100110: alu_salida = alu_dato1 ^ alu_dato2;
            6'b000011: alu_salida = $signed(alu_dato1) >>> alu_dato2;
            6'b000010: alu_salida = alu_dato1 >> alu_dato2;
            6'b100111: alu_salida = ~(alu_dato1 | alu_dato2);
            default:   alu_salida = 8'hAA;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        int   n;
        logic acc;
        n        = 0;
        in_data  = b;
        in_valid = 1'b1;
        do begin
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 20);
        in_valid = 1'b0;
        chk("beat_accepted", 32'(acc), 32'd1);
    endtask

    task automatic get_result(input logic [7:0] exp_d, input logic exp_e);
        int n;
        n         = 0;
        res_ready = 1'b1;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        chk("res_valid", 32'(res_valid), 32'd1);
        chk("res_data", 32'(res_data), 32'(exp_d));
        chk("res_err", 32'(res_err), 32'(exp_e));
        tick();
        res_ready = 1'b0;
        exp_cnt   = exp_cnt + 8'd1;
        chk("res_valid_drop", 32'(res_valid), 32'd0);
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    endtask

    initial begin
        bb   = '{8'h06, 8'h04, 8'h22, 8'h06, 8'h04, 8'h24};
        bexp = '{8'h02, 8'h04};
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        res_ready = 1'b0;

        // Reset values
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_dato1", 32'(alu_dato1), 32'd0);
        chk("rst_op", 32'(alu_op_code), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // ADD with latency observation (res_ready low while waiting)
        push(8'h06);
        push(8'h04);
        push(8'h20);
        chk("exec_valid_low", 32'(res_valid), 32'd0);
        chk("exec_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        tick();
        chk("lat_res_valid", 32'(res_valid), 32'd1);
        chk("lat_res_data", 32'(res_data), 32'h0A);
        get_result(8'h0A, 1'b0);

        // Back-to-back SUB then AND with in_valid and res_ready tied high
        res_ready = 1'b1;
        in_valid  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_data = (c % 5 < 3) ? bb[(c / 5) * 3 + (c % 5)] : 8'hFF;
            chk("b2b_in_ready", 32'(in_ready), (c % 5 < 3) ? 32'd1 : 32'd0);
            if (c % 5 == 4) begin
                chk("b2b_res_valid", 32'(res_valid), 32'd1);
                chk("b2b_res_data", 32'(res_data), 32'(bexp[c / 5]));
                chk("b2b_res_err", 32'(res_err), 32'd0);
            end
            tick();
        end
        in_valid  = 1'b0;
        res_ready = 1'b0;
        exp_cnt   = exp_cnt + 8'd2;
        chk("b2b_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

        // Illegal op code forces zero result with err flag
        push(8'h06);
        push(8'h04);
        push(8'h3F);
        get_result(8'h00, 1'b1);

        // Backpressure: result held, offered beats ignored
        push(8'h06);
        push(8'h04);
        push(8'h20);
        in_data  = 8'h55;
        in_valid = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("hold_res_valid", 32'(res_valid), 32'd1);
            chk("hold_res_data", 32'(res_data), 32'h0A);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        chk("hold_res_err", 32'(res_err), 32'd0);
        res_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        res_ready = 1'b0;
        exp_cnt   = exp_cnt + 8'd1;
        chk("hold_done_valid", 32'(res_valid), 32'd0);
        chk("hold_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        chk("hold_dato1_kept", 32'(alu_dato1), 32'h06);

        // clear drops the beat offered in the same cycle
        push(8'h06);
        in_data  = 8'h04;
        in_valid = 1'b1;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clear_in_ready", 32'(in_ready), 32'd1);
        chk("clear_dato1_kept", 32'(alu_dato1), 32'h06);
        push(8'h09);
        push(8'h01);
        push(8'h20);
        get_result(8'h0A, 1'b0);

        // Asynchronous reset after operand 2
        push(8'h06);
        push(8'h04);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_dato1", 32'(alu_dato1), 32'd0);
        chk("arst_dato2", 32'(alu_dato2), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("arst_res_data", 32'(res_data), 32'd0);
        exp_cnt = '0;
        #2;
        rst_n = 1'b1;
        tick();
        chk("arst_in_ready_up", 32'(in_ready), 32'd1);
        push(8'h06);
        push(8'h04);
        push(8'h20);
        get_result(8'h0A, 1'b0);

        // Counter wrap after 256 frames total
        for (int i = 0; i < 255; i++) begin
            push(8'(i));
            push(8'h01);
            push(8'h20);
            get_result(8'(i + 1), 1'b0);
        end
        chk("wrap_frame_cnt", 32'(frame_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
